// File: rtl/alu_ctl_pkg.sv
// Shared encodings for the ALU control stage: op/branch codes, major opcodes,
// and the decoded-entry record stored in the skid buffer.
package alu_ctl_pkg;

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_SRL   = 4'b0011;
  localparam logic [3:0] OP_SRA   = 4'b0100;
  localparam logic [3:0] OP_SLL   = 4'b0101;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_XOR   = 4'b1000;
  localparam logic [3:0] OP_CSRRW = 4'b1001;
  localparam logic [3:0] OP_CSRRS = 4'b1010;
  localparam logic [3:0] OP_CSRRC = 4'b1011;

  localparam logic [2:0] BR_NONE = 3'b000;
  localparam logic [2:0] BR_BEQ  = 3'b001;
  localparam logic [2:0] BR_BNE  = 3'b010;
  localparam logic [2:0] BR_BLT  = 3'b011;
  localparam logic [2:0] BR_BGE  = 3'b100;
  localparam logic [2:0] BR_BLTU = 3'b101;
  localparam logic [2:0] BR_BGEU = 3'b110;

  localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic [6:0] aluctl;
    logic       sltu;
    logic       illegal;
  } dec_t;

  function automatic logic [6:0] pack_aluctl(input logic [2:0] br, input logic [3:0] op);
    return {br, op};
  endfunction

endpackage

// File: rtl/alu_ctl_decode.sv
// Combinational decode of (opcode, funct3, funct7) into the 7-bit ALU control
// word, the unsigned-compare result-select flag and the illegal flag.
module alu_ctl_decode
  import alu_ctl_pkg::*;
(
  input  logic [6:0] i_opcode,
  input  logic [2:0] i_funct3,
  input  logic [6:0] i_funct7,
  output logic [6:0] o_aluctl,
  output logic       o_sltu,
  output logic       o_illegal
);

  logic [3:0] w_alu_op;
  logic [3:0] w_op;
  logic [2:0] w_br;
  logic       w_sltu;
  logic       w_illegal;

  // funct3 mapping shared by register and immediate arithmetic
  always_comb begin
    w_alu_op = OP_ADD;
    case (i_funct3)
      3'b000:  w_alu_op = OP_ADD;
      3'b001:  w_alu_op = OP_SLL;
      3'b010:  w_alu_op = OP_SLT;
      3'b011:  w_alu_op = OP_SUB;
      3'b100:  w_alu_op = OP_XOR;
      3'b101:  w_alu_op = OP_SRL;
      3'b110:  w_alu_op = OP_OR;
      default: w_alu_op = OP_AND;
    endcase
  end

  always_comb begin
    w_op      = OP_ADD;
    w_br      = BR_NONE;
    w_sltu    = 1'b0;
    w_illegal = 1'b0;
    case (i_opcode)
      OPC_RTYPE: begin
        w_op = w_alu_op;
        if (i_funct3 == 3'b011) begin
          w_br   = BR_BLTU;
          w_sltu = 1'b1;
        end
        if (i_funct7 == F7_ALT) begin
          if (i_funct3 == 3'b000)      w_op = OP_SUB;
          else if (i_funct3 == 3'b101) w_op = OP_SRA;
          else                         w_illegal = 1'b1;
        end else if (i_funct7 != F7_ZERO) begin
          w_illegal = 1'b1;
        end
      end
      OPC_ITYPE: begin
        w_op = w_alu_op;
        if (i_funct3 == 3'b011) begin
          w_br   = BR_BLTU;
          w_sltu = 1'b1;
        end
        // funct7 is immediate bits except for the shift encodings
        if (i_funct3 == 3'b001 && i_funct7 != F7_ZERO) w_illegal = 1'b1;
        if (i_funct3 == 3'b101) begin
          if (i_funct7 == F7_ALT)        w_op = OP_SRA;
          else if (i_funct7 != F7_ZERO)  w_illegal = 1'b1;
        end
      end
      OPC_BRANCH: begin
        w_op = OP_SUB;
        case (i_funct3)
          3'b000:  w_br = BR_BEQ;
          3'b001:  w_br = BR_BNE;
          3'b100:  w_br = BR_BLT;
          3'b101:  w_br = BR_BGE;
          3'b110:  w_br = BR_BLTU;
          3'b111:  w_br = BR_BGEU;
          default: w_illegal = 1'b1;
        endcase
      end
      OPC_LOAD, OPC_STORE, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_FENCE: begin
        w_op = OP_ADD;
      end
      OPC_SYSTEM: begin
        case (i_funct3)
          3'b000:          w_op = OP_ADD;
          3'b001, 3'b101:  w_op = OP_CSRRW;
          3'b010, 3'b110:  w_op = OP_CSRRS;
          3'b011, 3'b111:  w_op = OP_CSRRC;
          default:         w_illegal = 1'b1;
        endcase
      end
      default: w_illegal = 1'b1;
    endcase
  end

  assign o_aluctl  = w_illegal ? pack_aluctl(BR_NONE, OP_ADD) : pack_aluctl(w_br, w_op);
  assign o_sltu    = w_sltu & ~w_illegal;
  assign o_illegal = w_illegal;

endmodule

// File: rtl/alu_control_stage.sv
// Registered ALU-control decode stage: decodes at the input and holds results
// in a 2-entry skid buffer with valid/ready on both sides and a sync flush.
module alu_control_stage
  import alu_ctl_pkg::*;
#(
  parameter int TAG_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       in_opcode,
  input  logic [2:0]       in_funct3,
  input  logic [6:0]       in_funct7,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [6:0]       out_aluctl,
  output logic             out_sltu,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag
);

  logic [1:0]       r_count;
  logic             r_in_ready;
  dec_t             r_head_dec;
  dec_t             r_spare_dec;
  logic [TAG_W-1:0] r_head_tag;
  logic [TAG_W-1:0] r_spare_tag;

  logic [6:0]       w_aluctl;
  logic             w_sltu;
  logic             w_illegal;
  dec_t             w_dec;
  logic             w_accept;
  logic             w_pop;
  logic [1:0]       w_count_nxt;

  alu_ctl_decode u_decode (
    .i_opcode  (in_opcode),
    .i_funct3  (in_funct3),
    .i_funct7  (in_funct7),
    .o_aluctl  (w_aluctl),
    .o_sltu    (w_sltu),
    .o_illegal (w_illegal)
  );

  assign w_dec    = '{aluctl: w_aluctl, sltu: w_sltu, illegal: w_illegal};
  assign w_accept = in_valid & r_in_ready;
  assign w_pop    = (r_count != 2'd0) & out_ready;

  always_comb begin
    w_count_nxt = r_count;
    if (flush)                    w_count_nxt = 2'd0;
    else if (w_accept && !w_pop)  w_count_nxt = r_count + 2'd1;
    else if (!w_accept && w_pop)  w_count_nxt = r_count - 2'd1;
  end

  // in_ready is registered from the next count so it never depends on out_ready combinationally
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count    <= 2'd0;
      r_in_ready <= 1'b1;
    end else begin
      r_count    <= w_count_nxt;
      r_in_ready <= (w_count_nxt != 2'd2);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_head_dec  <= '0;
      r_spare_dec <= '0;
      r_head_tag  <= '0;
      r_spare_tag <= '0;
    end else if (!flush) begin
      if (w_pop) begin
        if (r_count == 2'd2) begin
          r_head_dec <= r_spare_dec;
          r_head_tag <= r_spare_tag;
        end else if (w_accept) begin
          r_head_dec <= w_dec;
          r_head_tag <= in_tag;
        end
      end else if (w_accept) begin
        if (r_count == 2'd0) begin
          r_head_dec <= w_dec;
          r_head_tag <= in_tag;
        end else begin
          r_spare_dec <= w_dec;
          r_spare_tag <= in_tag;
        end
      end
    end
  end

  assign in_ready    = r_in_ready;
  assign out_valid   = (r_count != 2'd0);
  assign out_aluctl  = r_head_dec.aluctl;
  assign out_sltu    = r_head_dec.sltu;
  assign out_illegal = r_head_dec.illegal;
  assign out_tag     = r_head_tag;

endmodule

// File: tb/tb_alu_control_stage.sv
// Scoreboard bench for alu_control_stage: directed scenarios plus randomized
// traffic, checked against a table-driven decode model and a queue model.
module tb_alu_control_stage;

  localparam int TAG_W = 32;

  logic             clk = 1'b0;
  logic             reset_n = 1'b1;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [6:0]       in_opcode = '0;
  logic [2:0]       in_funct3 = '0;
  logic [6:0]       in_funct7 = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [6:0]       out_aluctl;
  logic             out_sltu;
  logic             out_illegal;
  logic [TAG_W-1:0] out_tag;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic [6:0]       aluctl;
    logic             sltu;
    logic             ill;
    logic [TAG_W-1:0] tag;
  } exp_t;

  exp_t sb[$];

  logic [6:0] opc_tab [11] = '{7'h33, 7'h13, 7'h63, 7'h03, 7'h23, 7'h37,
                               7'h17, 7'h6F, 7'h67, 7'h0F, 7'h73};

  alu_control_stage #(.TAG_W(TAG_W)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_opcode   (in_opcode),
    .in_funct3   (in_funct3),
    .in_funct7   (in_funct7),
    .in_tag      (in_tag),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_aluctl  (out_aluctl),
    .out_sltu    (out_sltu),
    .out_illegal (out_illegal),
    .out_tag     (out_tag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference decode, returns {illegal, sltu, branch[2:0], op[3:0]}
  function automatic logic [8:0] ref_decode(input logic [6:0] opc, input logic [2:0] f3,
                                            input logic [6:0] f7);
    int alu_tab [8];
    int br_tab  [8];
    int op;
    int br;
    bit sl;
    bit ill;
    alu_tab = '{2, 5, 7, 6, 8, 3, 1, 0};
    br_tab  = '{1, 2, 0, 0, 3, 4, 5, 6};
    op = 2; br = 0; sl = 0; ill = 0;
    if (opc == 7'h33 || opc == 7'h13) begin
      op = alu_tab[f3];
      if (f3 == 3) begin br = 5; sl = 1; end
      if (opc == 7'h33) begin
        if (f7 == 7'h20 && f3 == 0)      op = 6;
        else if (f7 == 7'h20 && f3 == 5) op = 4;
        else if (f7 != 0)                ill = 1;
      end else begin
        if (f3 == 1 && f7 != 0) ill = 1;
        if (f3 == 5 && f7 == 7'h20) op = 4;
        else if (f3 == 5 && f7 != 0) ill = 1;
      end
    end else if (opc == 7'h63) begin
      op = 6;
      br = br_tab[f3];
      if (br == 0) ill = 1;
    end else if (opc inside {7'h03, 7'h23, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h0F}) begin
      op = 2;
    end else if (opc == 7'h73) begin
      if (f3 == 0)                op = 2;
      else if (f3 == 4)           ill = 1;
      else                        op = 8 + ((f3 - 1) % 4) + 1;
    end else begin
      ill = 1;
    end
    if (ill) begin op = 2; br = 0; sl = 0; end
    return {ill, sl, 3'(br), 4'(op)};
  endfunction

  // Monitor / scoreboard: compares the head entry every cycle it is presented
  always @(negedge clk) begin
    exp_t e;
    if (!reset_n || flush) begin
      sb.delete();
    end else begin
      chk("in_ready_vs_model", in_ready, 64'(sb.size() < 2));
      chk("out_valid_vs_model", out_valid, 64'(sb.size() > 0));
      if (out_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_out_tag", out_tag, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          chk("sb_aluctl", out_aluctl, sb[0].aluctl);
          chk("sb_sltu", out_sltu, sb[0].sltu);
          chk("sb_illegal", out_illegal, sb[0].ill);
          chk("sb_tag", out_tag, sb[0].tag);
          if (out_ready) void'(sb.pop_front());
        end
      end
      if (in_valid && in_ready) begin
        {e.ill, e.sltu, e.aluctl} = ref_decode(in_opcode, in_funct3, in_funct7);
        e.tag = in_tag;
        sb.push_back(e);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                      input logic [TAG_W-1:0] tag);
    int t;
    t = 0;
    in_valid = 1'b1; in_opcode = opc; in_funct3 = f3; in_funct7 = f7; in_tag = tag;
    @(negedge clk);
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) chk("send_timeout", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_check(input string name, input logic [6:0] opc, input logic [2:0] f3,
                            input logic [6:0] f7, input logic [6:0] x_ctl,
                            input logic x_sltu, input logic x_ill);
    send(opc, f3, f7, 32'hA000_0000 | 32'(opc));
    @(negedge clk);
    chk({name, "_valid"}, out_valid, 1);
    chk({name, "_aluctl"}, out_aluctl, x_ctl);
    chk({name, "_sltu"}, out_sltu, x_sltu);
    chk({name, "_illegal"}, out_illegal, x_ill);
    tick();
  endtask

  initial begin
    int t;
    #2 reset_n = 1'b0;
    #10;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_aluctl", out_aluctl, 0);
    chk("rst_sltu", out_sltu, 0);
    chk("rst_illegal", out_illegal, 0);
    chk("rst_tag", out_tag, 0);
    reset_n = 1'b1;
    tick();

    out_ready = 1'b1;
    send_check("sub", 7'h33, 3'b000, 7'h20, 7'b0000110, 1'b0, 1'b0);
    send_check("bltu", 7'h63, 3'b110, 7'h00, 7'b1010110, 1'b0, 1'b0);
    send_check("sltiu", 7'h13, 3'b011, 7'h55, 7'b1010110, 1'b1, 1'b0);
    send_check("ill_opc", 7'h7F, 3'b000, 7'h00, 7'b0000010, 1'b0, 1'b1);
    send_check("ill_br", 7'h63, 3'b010, 7'h00, 7'b0000010, 1'b0, 1'b1);
    send_check("sra", 7'h33, 3'b101, 7'h20, 7'b0000100, 1'b0, 1'b0);
    send_check("csrrc", 7'h73, 3'b111, 7'h00, 7'b0001011, 1'b0, 1'b0);

    // Backpressure: two entries fill the buffer, the third waits for a pop
    out_ready = 1'b0;
    send(7'h33, 3'b000, 7'h00, 32'h10);
    send(7'h33, 3'b111, 7'h00, 32'h20);
    in_valid = 1'b1; in_opcode = 7'h13; in_funct3 = 3'b100; in_tag = 32'h30;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_hold_tag", out_tag, 32'h10);
    end
    tick();
    out_ready = 1'b1;
    send(7'h13, 3'b100, 7'h00, 32'h30);
    tick();
    tick();

    // Flush with a full buffer and an input presented
    out_ready = 1'b0;
    send(7'h03, 3'b010, 7'h00, 32'h40);
    send(7'h23, 3'b010, 7'h00, 32'h50);
    in_valid = 1'b1; in_tag = 32'hDEAD; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("flush2_out_valid", out_valid, 0);
    chk("flush2_in_ready", in_ready, 1);
    tick();
    // Flush with one entry while an acceptable input is presented
    send(7'h37, 3'b000, 7'h00, 32'h60);
    in_valid = 1'b1; in_tag = 32'hBEEF; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("flush1_out_valid", out_valid, 0);
    tick();

    // Asynchronous reset mid-stream with one entry held
    send(7'h33, 3'b110, 7'h00, 32'h70);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_in_ready", in_ready, 1);
    #5 reset_n = 1'b1;
    tick();
    out_ready = 1'b1;
    send_check("post_rst", 7'h33, 3'b000, 7'h20, 7'b0000110, 1'b0, 1'b0);

    // Randomized traffic with random backpressure and occasional flush
    for (int c = 0; c < 3000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_opcode = ($urandom_range(0, 3) == 0) ? 7'($urandom) : opc_tab[$urandom_range(0, 10)];
      in_funct3 = 3'($urandom);
      case ($urandom_range(0, 3))
        0, 1:    in_funct7 = 7'h00;
        2:       in_funct7 = 7'h20;
        default: in_funct7 = 7'($urandom);
      endcase
      in_tag    = $urandom;
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 99) == 0);
      tick();
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    t = 0;
    while (sb.size() > 0 && t < 20) begin
      tick();
      t++;
    end
    chk("drain_left", 64'(sb.size()), 0);
    @(negedge clk);
    chk("drain_out_valid", out_valid, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
